// File: rtl/matrix_mul_ctrl.sv
// Job sequencer for the matrix Multiplier: streams operand bytes in, enables the
// arithmetic unit, and collects one product per row into a small result FIFO.
module matrix_mul_ctrl #(
  parameter int LOAD_BYTES = 160,
  parameter int N_ROWS     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mul_load_en,
  output logic        mul_au_en,
  output logic [7:0]  mul_x,
  input  logic        mul_xload_done,
  input  logic        mul_row_done,
  input  logic [15:0] mul_p,
  output logic        res_valid,
  output logic [15:0] res_data,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic        err_ovf,
  output logic        err_tmo,
  output logic [7:0]  rows_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [7:0]       LOAD_MAX  = 8'(LOAD_BYTES);
  localparam logic [7:0]       LOAD_LAST = 8'(LOAD_BYTES - 1);
  localparam logic [7:0]       ROWS_MAX  = 8'(N_ROWS);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_X  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       rows_cnt_q, rows_cnt_d;
  logic [7:0]       mul_x_q, mul_x_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_tmo_q, err_tmo_d;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic accept_s;
  logic pop_s;
  logic full_s;
  logic row_evt_s;
  logic push_s;
  logic drop_s;
  logic flush_s;

  assign full_s    = (fifo_cnt_q == DEPTH_C);
  assign accept_s  = in_ready && in_valid;
  assign pop_s     = res_valid && res_ready;
  assign row_evt_s = (state_q == S_COMPUTE) && mul_row_done;
  // A pop on the same edge frees the slot, so a full FIFO can still take the row.
  assign push_s    = row_evt_s && (!full_s || pop_s);
  assign drop_s    = row_evt_s && full_s && !pop_s;

  // Occupancy after this edge; DRAIN uses it to leave as soon as the last entry goes.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push_s && !pop_s) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (!push_s && pop_s) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end else begin
      fifo_cnt_d = fifo_cnt_q;
    end
  end

  // Next-state and counter/flag update logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rows_cnt_d = rows_cnt_q;
    mul_x_d    = mul_x_q;
    err_ovf_d  = err_ovf_q || drop_s;
    err_tmo_d  = err_tmo_q;
    flush_s    = 1'b0;

    if (row_evt_s && (rows_cnt_q != 8'hFF)) begin
      rows_cnt_d = rows_cnt_q + 8'd1;
    end else begin
      rows_cnt_d = rows_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          byte_cnt_d = 8'd0;
          tmo_cnt_d  = '0;
          rows_cnt_d = 8'd0;
          err_ovf_d  = 1'b0;
          err_tmo_d  = 1'b0;
          state_d    = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (accept_s) begin
          mul_x_d    = in_data;
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (byte_cnt_q == LOAD_LAST) begin
            tmo_cnt_d = '0;
            state_d   = S_WAIT_X;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WAIT_X: begin
        if (mul_xload_done) begin
          state_d = S_COMPUTE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_COMPUTE: begin
        if (rows_cnt_q >= ROWS_MAX) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_COMPUTE;
        end
      end
      S_DRAIN: begin
        if (fifo_cnt_d == '0) begin
          state_d = S_FIN;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the job without a done pulse but keeps the sticky error flags.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      byte_cnt_d = 8'd0;
      tmo_cnt_d  = '0;
      rows_cnt_d = 8'd0;
      err_ovf_d  = err_ovf_q;
      err_tmo_d  = err_tmo_q;
      flush_s    = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
  end

  // Control state, counters, operand byte and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 8'd0;
      tmo_cnt_q  <= '0;
      rows_cnt_q <= 8'd0;
      mul_x_q    <= 8'h00;
      err_ovf_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rows_cnt_q <= rows_cnt_d;
      mul_x_q    <= mul_x_d;
      err_ovf_q  <= err_ovf_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  // Result FIFO storage and pointers; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (flush_s) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= mul_p;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign in_ready    = (state_q == S_LOAD) && (byte_cnt_q < LOAD_MAX);
  assign mul_load_en = (state_q == S_LOAD) || (state_q == S_WAIT_X);
  assign mul_au_en   = (state_q == S_COMPUTE) && !full_s;
  assign mul_x       = mul_x_q;
  assign res_valid   = (fifo_cnt_q != '0);
  assign res_data    = mem_q[rd_ptr_q];
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err_ovf     = err_ovf_q;
  assign err_tmo     = err_tmo_q;
  assign rows_cnt    = rows_cnt_q;

endmodule

// File: doc/matrix_mul_ctrl.md
# matrix_mul_ctrl

Sequencer for the matrix-peripheral `Multiplier` datapath. It runs three phases in order:
- **Load:** streams operand bytes from an upstream valid/ready source into the multiplier's load port.
- **Compute:** enables the arithmetic unit.
- **Drain:** collects one 16-bit product per completed row into a small result FIFO with valid/ready output.

It sits between the peripheral's bus-side register/stream logic and the multiplier instance, replacing bench-driven enables with a hardware start/done handshake.

## Interface
Parameters:
- `LOAD_BYTES`, 160, operand bytes streamed per job (1..255).
- `N_ROWS`, 4, `row_done` pulses expected per job (1..255).
- `FIFO_DEPTH`, 4, result FIFO entries (power of two, ≥2).
- `TIMEOUT`, 1023, max cycles to wait for `mul_xload_done` after the last byte.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle job request; ignored unless in IDLE.
- `abort` in 1: synchronous job cancel.
- `in_valid` in 1 / `in_data` in 8 / `in_ready` out 1: operand byte stream.
- `mul_load_en` out 1: drives multiplier `input_load_en`.
- `mul_au_en` out 1: drives multiplier `AU_en`.
- `mul_x` out 8: drives multiplier `X_load`.
- `mul_xload_done` in 1: multiplier load complete.
- `mul_row_done` in 1: one-cycle pulse, a row product is valid on `mul_p`.
- `mul_p` in 16: multiplier product.
- `res_valid` out 1 / `res_data` out 16 / `res_ready` in 1: result stream.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at job end.
- `err_ovf` out 1: sticky; a row result was dropped.
- `err_tmo` out 1: sticky; the load handshake timed out.
- `rows_cnt` out 8: rows captured in the current job.

## Operation
States: IDLE → LOAD → WAIT_X → COMPUTE → DRAIN → FIN → IDLE.
- **IDLE:** all enables low. On `start`:
  - clear `rows_cnt`, the byte counter, `err_ovf` and `err_tmo`;
  - go to LOAD.
- **LOAD:**
  - `mul_load_en`=1.
  - `in_ready`=1 while byte count < `LOAD_BYTES`.
  - On `in_valid && in_ready`: `mul_x` <= `in_data`, count++.
  - When count reaches `LOAD_BYTES`, go to WAIT_X.
  - `in_valid` low simply stalls the phase; there is no timeout in LOAD.
- **WAIT_X:**
  - `mul_load_en` stays 1; `in_ready`=0; the timeout counter runs.
  - `mul_xload_done`=1 → go to COMPUTE.
  - Counter reaches `TIMEOUT` → set `err_tmo`, go to FIN without computing.
- **COMPUTE:**
  - `mul_load_en`=0.
  - `mul_au_en` = 1 unless the FIFO is full. Deasserting it is the backpressure stall.
  - Each `mul_row_done` pulse pushes `mul_p` and increments `rows_cnt`.
  - If the FIFO is full with no simultaneous pop, the product is dropped and `err_ovf` is set; `rows_cnt` still increments.
  - `rows_cnt` == `N_ROWS` → go to DRAIN.
- **DRAIN:** `mul_au_en`=0. Go to FIN when the FIFO is empty.
- **FIN:** `done`=1 for exactly one cycle, then IDLE.
- **FIFO:**
  - `res_valid` = not empty; `res_data` = head entry (first-word fall-through).
  - Pop on `res_valid && res_ready`.
  - A push and pop in the same cycle while full are both accepted, with no overflow.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **abort** (any state except IDLE): next state is IDLE; FIFO flushed; counters cleared; `done` is not pulsed; error flags kept.
  - `abort` and `start` in the same IDLE cycle: `start` wins.
- **Counters:** `rows_cnt` saturates at 255; the byte counter is 8 bits.

## Timing
- **Reset values:**
  - `in_ready`, `mul_load_en`, `mul_au_en`, `res_valid`, `busy`, `done`, `err_ovf`, `err_tmo` = 0;
  - `mul_x` = 8'h00; `res_data` = 16'h0000; `rows_cnt` = 0;
  - state = IDLE; FIFO empty.
- **Registers:** all outputs are registered or decoded from state and registers only. No combinational path from `in_valid`, `res_ready` or `mul_*` inputs to any output.
- **Job start:** `start` at cycle t → `busy` and `mul_load_en` high at t+1, `in_ready` high at t+1.
- **Load data:** a byte accepted at edge t appears on `mul_x` after edge t.
- **End of load:** the last byte accepted at edge t → WAIT_X from t+1, with `in_ready` low.
- **Into compute:** `mul_xload_done` sampled high at edge t → `mul_load_en` low and `mul_au_en` high from t+1.
- **Row capture:** `mul_row_done` at edge t → `res_valid` high from t+1 (if the FIFO was empty) and `rows_cnt` incremented at t+1.
- **Stall:** FIFO becomes full at edge t → `mul_au_en` low from t+1. A row pulse on that same edge t is still captured or flagged per the rules above.
- **Job end:** the last pop at edge t with DRAIN and FIFO empty → FIN at t+1, `done` at t+1, IDLE (`busy` low) at t+2.
- **Timeout:** `err_tmo` is set exactly `TIMEOUT` cycles after entry to WAIT_X.
- **Mid-job reset:** `rst` mid-job clears everything immediately, asynchronously.

## Test plan
- **Nominal job:** `start`; 160 bytes streamed with `in_valid` held high (0x00..0x9F); `xload_done` 3 cycles later; 4 `row_done` pulses with P = 0x0001..0x0004; `res_ready`=1 → results 1,2,3,4 in order, `done` pulse once, `busy` low after, no error flags.
- **Gapped source:** `in_valid` toggling every other cycle → exactly 160 accepts, `mul_x` tracks each accepted byte, LOAD lasts 320 cycles.
- **Backpressure:** `res_ready`=0 throughout COMPUTE with `FIFO_DEPTH`=4 → `mul_au_en` drops after the 4th capture. A 5th pulse forced while full sets `err_ovf`. With `res_ready` then raised, only the 4 stored values are popped.
- **Full-FIFO push and pop:** `row_done` coincident with a pop while full → no overflow, order preserved.
- **Timeout:** `mul_xload_done` never asserted → `err_tmo`=1 at WAIT_X entry + 1023 cycles, `done` pulses, `mul_au_en` never high.
- **Abort and reset mid-job:** `abort` in COMPUTE after 2 rows → IDLE next cycle, FIFO empty, no `done`. `rst` asserted mid-LOAD → all outputs at reset values immediately, and a following `start` runs a clean nominal job.
